// File: rtl/exu_bju_pkg.sv
// Shared types and constants for the EXU branch/jump unit.
// BJU_PRED_CHECK_EN adds prediction fields to the queued entry.
package exu_bju_pkg;

  localparam int BJU_XLEN   = 64;
  localparam int BJU_IID_W  = 4;
  localparam int BJU_PREG_W = 6;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [BJU_IID_W-1:0]  iid;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  rvc;
    logic [BJU_XLEN-1:0]   pc;
    logic [BJU_XLEN-1:0]   src1;
    logic [BJU_XLEN-1:0]   src2;
    logic [BJU_XLEN-1:0]   imm;
    logic                  pdst_vld;
    logic [BJU_PREG_W-1:0] pdst;
`ifdef BJU_PRED_CHECK_EN
    logic                  pred_taken;
    logic [BJU_XLEN-1:0]   pred_target;
`endif
  } bju_entry_t;

endpackage

// File: rtl/exu_bju_fifo.sv
// DEPTH-entry circular queue of branch/jump entries.
// Non-power-of-two depths wrap explicitly.
module exu_bju_fifo
  import exu_bju_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  bju_entry_t                 push_data,
  input  logic                       pop,
  output bju_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  bju_entry_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/exu_bju_pipe.sv
// Buffered two-stage branch/jump unit: queue -> E1 resolve -> E2 report.
// BJU_PRED_CHECK_EN: redirect only on misprediction instead of every taken op.
module exu_bju_pipe
  import exu_bju_pkg::*;
#(
  parameter int XLEN   = BJU_XLEN,
  parameter int IID_W  = BJU_IID_W,
  parameter int PREG_W = BJU_PREG_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,
  input  logic              idu_exu_bju_vld,
  output logic              idu_exu_bju_rdy,
  input  logic [IID_W-1:0]  idu_exu_bju_iid,
  input  logic [6:0]        idu_exu_bju_opcode,
  input  logic [2:0]        idu_exu_bju_funct3,
  input  logic              idu_exu_bju_rvc,
  input  logic [XLEN-1:0]   idu_exu_bju_pc,
  input  logic [XLEN-1:0]   idu_exu_bju_psrc1_value,
  input  logic [XLEN-1:0]   idu_exu_bju_psrc2_value,
  input  logic [XLEN-1:0]   idu_exu_bju_imm,
  input  logic              idu_exu_bju_pdst_vld,
  input  logic [PREG_W-1:0] idu_exu_bju_pdst,
`ifdef BJU_PRED_CHECK_EN
  input  logic              idu_exu_bju_pred_taken,
  input  logic [XLEN-1:0]   idu_exu_bju_pred_target,
`endif
  output logic              exu_rtu_rob_bju_complete,
  output logic [IID_W-1:0]  exu_rtu_rob_bju_iid,
  output logic              exu_idu_rf_bju_wb_vld,
  output logic [PREG_W-1:0] exu_idu_rf_bju_wb_preg,
  output logic [XLEN-1:0]   exu_idu_rf_bju_wb_data,
  input  logic              exu_idu_rf_bju_wb_rdy,
  output logic              exu_idu_rf_bju_pcjump_vld,
  output logic [XLEN-1:0]   exu_idu_rf_bju_pcjump_addr
);

  localparam int CW = $clog2(DEPTH + 1);

  bju_entry_t    in_ent;
  bju_entry_t    head;
  bju_entry_t    e1;
  logic [CW-1:0] count;
  logic          e1_vld;
  logic          e2_vld;
  logic          e2_wb;
  logic          e2_pj;
  logic [IID_W-1:0]  e2_iid;
  logic [PREG_W-1:0] e2_pdst;
  logic [XLEN-1:0]   e2_link;
  logic [XLEN-1:0]   e2_addr;

  logic fire, fire_redirect, kill;
  logic e2_free, e1_free, accept;
  logic q_empty, thru, push, pop, load_e1;

  always_comb begin
    in_ent          = '0;
    in_ent.iid      = idu_exu_bju_iid;
    in_ent.opcode   = idu_exu_bju_opcode;
    in_ent.funct3   = idu_exu_bju_funct3;
    in_ent.rvc      = idu_exu_bju_rvc;
    in_ent.pc       = idu_exu_bju_pc;
    in_ent.src1     = idu_exu_bju_psrc1_value;
    in_ent.src2     = idu_exu_bju_psrc2_value;
    in_ent.imm      = idu_exu_bju_imm;
    in_ent.pdst_vld = idu_exu_bju_pdst_vld;
    in_ent.pdst     = idu_exu_bju_pdst;
`ifdef BJU_PRED_CHECK_EN
    in_ent.pred_taken  = idu_exu_bju_pred_taken;
    in_ent.pred_target = idu_exu_bju_pred_target;
`endif
  end

  assign fire = e2_vld & (~e2_wb | exu_idu_rf_bju_wb_rdy)
              & ~rtu_global_flush;
  assign fire_redirect = fire & e2_pj;
  assign kill    = rtu_global_flush | fire_redirect;
  assign e2_free = ~e2_vld | fire;
  assign e1_free = ~e1_vld | e2_free;

  assign idu_exu_bju_rdy = (count < CW'(DEPTH))
                         & ~fire_redirect & ~rtu_global_flush;
  assign accept  = idu_exu_bju_vld & idu_exu_bju_rdy;
  assign q_empty = (count == '0);
  // Bypass the queue when nothing older is waiting for E1.
  assign thru    = accept & q_empty & e1_free;
  assign push    = accept & ~thru;
  assign pop     = ~q_empty & e1_free & ~kill;
  assign load_e1 = thru | pop;

  exu_bju_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_clk),
    .clear     (kill),
    .push      (push),
    .push_data (in_ent),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk)
      e1_vld <= 1'b0;
    else if (kill)
      e1_vld <= 1'b0;
    else if (load_e1)
      e1_vld <= 1'b1;
    else if (e2_free)
      e1_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load_e1) e1 <= thru ? in_ent : head;
  end

  logic is_jal, is_jalr, is_br, lt, cond, taken, wb;
  logic pj;
  logic [XLEN-1:0] link, target, addr;
`ifdef BJU_PRED_CHECK_EN
  logic [XLEN-1:0] actual_next;
`endif

  always_comb begin
    is_jal  = (e1.opcode == OP_JAL);
    is_jalr = (e1.opcode == OP_JALR) & (e1.funct3 == F3_JALR);
    is_br   = (e1.opcode == OP_BRANCH);
    lt      = e1.funct3[1] ? (e1.src1 < e1.src2)
                           : ($signed(e1.src1) < $signed(e1.src2));
    cond    = (e1.funct3[2] ? lt : (e1.src1 == e1.src2)) ^ e1.funct3[0];
    taken   = is_jal | is_jalr | (is_br & cond);
    link    = e1.pc + (e1.rvc ? XLEN'(2) : XLEN'(4));
    target  = is_jalr ? ((e1.src1 + e1.imm) & ~XLEN'(1))
                      : (e1.pc + e1.imm);
    wb      = (is_jal | is_jalr) & e1.pdst_vld;
`ifdef BJU_PRED_CHECK_EN
    actual_next = taken ? target : link;
    pj   = (is_jal | is_jalr | is_br)
         & ((taken != e1.pred_taken)
         | (taken & (target != e1.pred_target)));
    addr = actual_next;
`else
    pj   = taken;
    addr = target;
`endif
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk)
      e2_vld <= 1'b0;
    else if (rtu_global_flush)
      e2_vld <= 1'b0;
    else if (e2_free)
      e2_vld <= e1_vld & ~fire_redirect;
  end

  always_ff @(posedge clk) begin
    if (e2_free && e1_vld) begin
      e2_iid  <= e1.iid;
      e2_wb   <= wb;
      e2_pj   <= pj;
      e2_pdst <= e1.pdst;
      e2_link <= link;
      e2_addr <= addr;
    end
  end

  assign exu_rtu_rob_bju_complete   = fire;
  assign exu_rtu_rob_bju_iid        = fire ? e2_iid : '0;
  assign exu_idu_rf_bju_wb_vld      = fire & e2_wb;
  assign exu_idu_rf_bju_wb_preg     = exu_idu_rf_bju_wb_vld ? e2_pdst : '0;
  assign exu_idu_rf_bju_wb_data     = exu_idu_rf_bju_wb_vld ? e2_link : '0;
  assign exu_idu_rf_bju_pcjump_vld  = fire_redirect;
  assign exu_idu_rf_bju_pcjump_addr = fire_redirect ? e2_addr : '0;

endmodule
